// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } mdState_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: E-stage controls/operands into the unit and HI/LO/status back out.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             startE;
  mdOp_e            opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hienE;
  logic             loenE;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output startE, opE, srcaE, srcbE, hienE, loenE, cancel,
    input  hi, lo, busy, done
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hienE, loenE, cancel,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negate (abs when negate = sign bit).
// Only built when MULDIV_SIGNED_EN is defined.
`ifdef MULDIV_SIGNED_EN
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule
`endif

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide that owns HI/LO.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise op bit 0 is ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  mdState_e           state;
  logic [CW-1:0]      count;
  logic               isDiv;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;

  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;
  logic [2*WIDTH-1:0] prodFix;
  logic               unusedBits;

`ifdef MULDIV_SIGNED_EN
  logic signedOp;
  logic negA;
  logic negB;
  logic negMain;
  logic negRem;

  assign signedOp = (md.opE == MD_MULT) || (md.opE == MD_DIV);
  assign negA     = signedOp & md.srcaE[WIDTH-1];
  assign negB     = signedOp & md.srcbE[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) absA (.value(md.srcaE), .negate(negA), .result(aMag));
  muldiv_signfix #(.WIDTH(WIDTH)) absB (.value(md.srcbE), .negate(negB), .result(bMag));

  // Product and quotient are negative when operand signs differ; remainder follows the dividend.
  muldiv_signfix #(.WIDTH(WIDTH))   fixQuo  (.value(acc[WIDTH-1:0]), .negate(negMain), .result(quoFix));
  muldiv_signfix #(.WIDTH(WIDTH))   fixRem  (.value(rem[WIDTH-1:0]), .negate(negRem),  .result(remFix));
  muldiv_signfix #(.WIDTH(2*WIDTH)) fixProd (.value(acc),            .negate(negMain), .result(prodFix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      negMain <= 1'b0;
      negRem  <= 1'b0;
    end else if (state == MD_IDLE && md.startE) begin
      negMain <= negA ^ negB;
      negRem  <= negA;
    end
  end

  assign unusedBits = rem[WIDTH];
`else
  assign aMag       = md.srcaE;
  assign bMag       = md.srcbE;
  assign quoFix     = acc[WIDTH-1:0];
  assign remFix     = rem[WIDTH-1:0];
  assign prodFix    = acc;
  assign unusedBits = rem[WIDTH] ^ md.opE[0];
`endif

  // One radix-2 step: multiply adds into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divTrial;
  logic             divOk;

  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign divShift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign divTrial = {1'b0, divShift} - {2'b00, opnd};
  assign divOk    = ~divTrial[WIDTH+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      count   <= '0;
      isDiv   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      rem     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      doneReg <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (md.startE) begin
            state <= MD_RUN;
            count <= '0;
            isDiv <= md.opE[1];
            opnd  <= md.opE[1] ? bMag : aMag;
            acc   <= {{WIDTH{1'b0}}, (md.opE[1] ? aMag : bMag)};
            rem   <= '0;
          end else begin
            if (md.hienE) hiReg <= md.srcaE;
            if (md.loenE) loReg <= md.srcaE;
          end
        end
        MD_RUN: begin
          if (md.cancel) begin
            state <= MD_IDLE;
          end else begin
            if (isDiv) begin
              rem <= divOk ? divTrial[WIDTH:0] : divShift;
              acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], divOk};
            end else begin
              acc <= {mulSum, acc[WIDTH-1:1]};
            end
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!md.cancel) begin
            if (isDiv) begin
              hiReg <= remFix;
              loReg <= quoFix;
            end else begin
              {hiReg, loReg} <= prodFix;
            end
            doneReg <= 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md.busy = (state != MD_IDLE);
  assign md.done = doneReg;
  assign md.hi   = hiReg;
  assign md.lo   = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit; results are checked by a scoreboard monitor on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] MULT_HI = 32'hFFFF_FFFF, MULT_LO = 32'hFFFF_FFF1;
  localparam logic [31:0] DIV_HI  = 32'hFFFF_FFFF, DIV_LO  = 32'hFFFF_FFFD;
  localparam logic [31:0] OVF_HI  = 32'h0000_0000, OVF_LO  = 32'h8000_0000;
`else
  localparam logic [31:0] MULT_HI = 32'h0000_0004, MULT_LO = 32'hFFFF_FFF1;
  localparam logic [31:0] DIV_HI  = 32'h0000_0001, DIV_LO  = 32'h7FFF_FFFC;
  localparam logic [31:0] OVF_HI  = 32'h8000_0000, OVF_LO  = 32'h0000_0000;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic clk;
  logic reset;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t expQ[$];
  exp_t monExp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with no result pending", bus.hi, bus.lo);
      end else begin
        monExp = expQ.pop_front();
        check({monExp.name, "_hi"}, 64'(bus.hi), 64'(monExp.hi));
        check({monExp.name, "_lo"}, 64'(bus.lo), 64'(monExp.lo));
      end
    end
  end

  task automatic issue(input mdOp_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input string name, input bit expectResult);
    exp_t e;
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    if (expectResult) begin
      e.hi = expHi; e.lo = expLo; e.name = name;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; latency counted from the start edge.
  task automatic waitDone(input string name, input bit timed);
    int cyc     = 0;
    int busyCyc = 0;
    bit seen    = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busyCyc++;
      if (bus.done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    if (timed) begin
      check({name, "_latency"}, 64'(cyc), 64'd34);
      check({name, "_busy_cycles"}, 64'(busyCyc), 64'd33);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int doneCount;
    reset      = 1'b1;
    bus.startE = 1'b0;
    bus.opE    = MD_MULT;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.hienE  = 1'b0;
    bus.loenE  = 1'b0;
    bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1);
    waitDone("multu_max", 1'b1);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, MULT_HI, MULT_LO, "mult_neg3x5", 1'b1);
    waitDone("mult_neg3x5", 1'b1);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_HI, DIV_LO, "div_neg7by2", 1'b1);
    waitDone("div_neg7by2", 1'b1);
    issue(MD_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0", 1'b1);
    waitDone("divu_by0", 1'b1);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, OVF_HI, OVF_LO, "div_ovf", 1'b1);
    waitDone("div_ovf", 1'b1);

    // MTHI then MTLO while idle
    bus.hienE = 1'b1;
    bus.srcaE = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.hienE = 1'b0;
    bus.loenE = 1'b1;
    bus.srcaE = 32'h0000_5678;
    @(negedge clk);
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_lo_unchanged", 64'(bus.lo), 64'(OVF_LO));
    @(posedge clk);
    #1;
    bus.loenE = 1'b0;
    @(negedge clk);
    check("mtlo_lo", 64'(bus.lo), 64'h5678);
    check("mtlo_hi", 64'(bus.hi), 64'h1234);
    check("mt_busy", 64'(bus.busy), 64'd0);

    // MTHI/MTLO attempted mid-multiply must be ignored
    issue(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.hienE = 1'b1;
    bus.loenE = 1'b1;
    bus.srcaE = 32'h0000_AAAA;
    @(posedge clk);
    #1;
    bus.hienE = 1'b0;
    bus.loenE = 1'b0;
    @(negedge clk);
    check("busy_mthi_hi_hold", 64'(bus.hi), 64'h1234);
    check("busy_mtlo_lo_hold", 64'(bus.lo), 64'h5678);
    waitDone("multu_6x7", 1'b0);

    // Cancel at RUN count 10
    issue(MD_MULTU, 32'd9, 32'd9, 32'd0, 32'd0, "cancelled", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_hi",   64'(bus.hi),   64'd0);
    check("cancel_lo",   64'(bus.lo),   64'd42);
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    check("cancel_no_done", 64'(doneCount), 64'd0);

    // cancel in IDLE does not block start; then back-to-back issue in the done cycle
    bus.cancel = 1'b1;
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "start_with_cancel", 1'b1);
    bus.cancel = 1'b0;
    waitDone("start_with_cancel", 1'b1);
    issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_divu", 1'b1);
    waitDone("b2b_divu", 1'b1);

    // Asynchronous reset mid-divide
    issue(MD_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, "reset_mid", 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_hi",   64'(bus.hi),   64'd0);
    check("async_reset_lo",   64'(bus.lo),   64'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 64'(bus.busy), 64'd0);

    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
